// File: rtl/toggle_counter_pkg.sv
// Shared mode encodings for the toggle counter and its bench.
// Pure type/constant package; no logic, latency or flow control of its own.
package tff_pkg;

    typedef enum logic [1:0] {
        MODE_HOLD   = 2'b00,
        MODE_TOGGLE = 2'b01,
        MODE_UP     = 2'b10,
        MODE_DOWN   = 2'b11
    } mode_e;

    localparam int MODE_W = 2;

endpackage

// File: rtl/toggle_counter_if.sv
// Control/data bundle between a toggle counter and whoever drives it.
// Wires only: no latency, no backpressure (the counter accepts one command per clk).
interface toggle_counter_if
    import tff_pkg::*;
#(
    parameter int WIDTH = 8
);
    logic             en;
    logic             load;
    logic [WIDTH-1:0] d;
    mode_e            mode;
    logic [WIDTH-1:0] t;
    logic [WIDTH-1:0] q;
    logic             tc;

    modport master (
        output en, load, d, mode, t,
        input  q, tc
    );

    modport slave (
        input  en, load, d, mode, t,
        output q, tc
    );
endinterface

// File: rtl/toggle_counter_tff_cell.sv
// Single T flip-flop with synchronous active-high reset and enable.
// Latency: one clk edge; no backpressure.
module tff_cell (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic t,
    output logic q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= 1'b0;
        end else if (en) begin
            q <= q ^ t;
        end
    end

endmodule

// File: rtl/toggle_counter.sv
// Loadable toggle / up / down counter built from WIDTH T flip-flops, with a wrap pulse on tc.
// Latency: inputs at edge N appear on q/tc right after edge N; no backpressure, en=0 simply holds.
module toggle_counter
    import tff_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MAX_COUNT = 2**WIDTH - 1
) (
    input  logic             clk,
    input  logic             rst,
    toggle_counter_if.slave  bus
);

    if (WIDTH < 1) begin : g_bad_width
        $error("toggle_counter: WIDTH must be at least 1");
    end
    if ((MAX_COUNT < 1) || (MAX_COUNT > 2**WIDTH - 1)) begin : g_bad_max
        $error("toggle_counter: MAX_COUNT out of range 1..2**WIDTH-1");
    end

    localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MAX_COUNT);

    logic [WIDTH-1:0] q_bits;
    logic [WIDTH-1:0] up_t;
    logic [WIDTH-1:0] dn_t;
    logic [WIDTH-1:0] nxt;
    logic [WIDTH-1:0] cell_t;
    logic [WIDTH-1:0] load_val;
    logic             at_top;
    logic             at_zero;
    logic             wrap;
    logic             tc_r;

    // Ripple toggle enables: bit i flips when all lower bits are 1 (up) or 0 (down).
    always_comb begin
        up_t    = '0;
        dn_t    = '0;
        up_t[0] = 1'b1;
        dn_t[0] = 1'b1;
        for (int i = 1; i < WIDTH; i++) begin
            up_t[i] = up_t[i-1] &  q_bits[i-1];
            dn_t[i] = dn_t[i-1] & ~q_bits[i-1];
        end
    end

    assign at_top   = (q_bits >= MAX_Q);
    assign at_zero  = (q_bits == '0);
    assign load_val = (bus.d > MAX_Q) ? MAX_Q : bus.d;

    always_comb begin
        nxt  = q_bits;
        wrap = 1'b0;
        if (bus.load) begin
            nxt = load_val;
        end else begin
            unique case (bus.mode)
                MODE_HOLD: begin
                    nxt = q_bits;
                end
                MODE_TOGGLE: begin
                    nxt = q_bits ^ bus.t;
                end
                MODE_UP: begin
                    if (at_top) begin
                        nxt  = '0;
                        wrap = 1'b1;
                    end else begin
                        nxt = q_bits ^ up_t;
                    end
                end
                MODE_DOWN: begin
                    if (at_zero) begin
                        nxt  = MAX_Q;
                        wrap = 1'b1;
                    end else begin
                        nxt = q_bits ^ dn_t;
                    end
                end
                default: begin
                    nxt = q_bits;
                end
            endcase
        end
    end

    // Loads and wraps reach the cells as ordinary toggles: flip exactly the bits that differ.
    assign cell_t = q_bits ^ nxt;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        tff_cell u_cell (
            .clk (clk),
            .rst (rst),
            .en  (bus.en),
            .t   (cell_t[i]),
            .q   (q_bits[i])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tc_r <= 1'b0;
        end else if (!bus.en) begin
            tc_r <= 1'b0;
        end else begin
            tc_r <= wrap;
        end
    end

    assign bus.q  = q_bits;
    assign bus.tc = tc_r;

endmodule
